audio_nios_pio_gen: RTL

Parametrised Avalon-MM parallel I/O slave, the successor to the single-bit SD-clock output port.
- Per-bit direction and atomic set/clear writes.
- Input synchronisation, per-bit edge capture and a maskable level interrupt.
- Sits on the Nios data bus. Bit-bangs SD-card lines (clk/cmd/dat) and reads codec and button status pins.

---
 rtl/audio_nios_pio_pkg.sv | 18 +
 rtl/audio_nios_pio_gen_if.sv | 25 ++
 rtl/audio_nios_pio_sync.sv | 60 ++++++
 rtl/audio_nios_pio_gen.sv | 105 ++++++++++
 4 files changed

// File: rtl/audio_nios_pio_pkg.sv
// Shared constants for the Nios parallel I/O slave: word addresses of the
// register map and encodings of the edge-capture selection.
package audio_nios_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam logic [1:0] PRIME_DONE = 2'd3;

endpackage

// File: rtl/audio_nios_pio_gen_if.sv
// Avalon-MM slave bus bundle for the parallel I/O port: zero-wait reads,
// single-cycle writes qualified by chipselect and an active-low write strobe.
interface audio_nios_pio_gen_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/audio_nios_pio_sync.sv
// Pin input path: two-flop synchroniser, one history flop and a per-bit edge
// detector that stays quiet until the pipeline has been refilled after reset.
module audio_nios_pio_sync
    import audio_nios_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [WIDTH-1:0] in_sync_o,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [1:0]       prime_q;
    logic [1:0]       prime_d;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] sel_w;
    logic             primed_w;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q  <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            prime_q <= '0;
        end else begin
            meta_q  <= in_port_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            prime_q <= prime_d;
        end
    end

    // Saturating count: three edges after reset the prev flop holds real pin data.
    assign prime_d  = (prime_q == PRIME_DONE) ? prime_q : prime_q + 2'd1;
    assign primed_w = (prime_q == PRIME_DONE);

    assign rise_w = sync_q & ~prev_q;
    assign fall_w = ~sync_q & prev_q;

    generate
        if (EDGE_TYPE == EDGE_RISE) begin : g_rise
            assign sel_w = rise_w;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign sel_w = fall_w;
        end else begin : g_any
            assign sel_w = rise_w | fall_w;
        end
    endgenerate

    assign in_sync_o = sync_q;
    assign edge_o    = primed_w ? sel_w : '0;

endmodule

// File: rtl/audio_nios_pio_gen.sv
// Avalon-MM parallel I/O slave: data/direction registers with atomic set and
// clear, synchronised inputs, write-1-to-clear edge capture and a masked irq.
module audio_nios_pio_gen
    import audio_nios_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter bit               IRQ_EN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    audio_nios_pio_gen_if.slave  avs,
    input  logic [WIDTH-1:0]     in_port,
    output logic [WIDTH-1:0]     out_port,
    output logic [WIDTH-1:0]     oe,
    output logic                 irq
);

    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] dir_q,  dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q,  cap_d;
    logic [WIDTH-1:0] cap_clr_w;
    logic [WIDTH-1:0] in_sync_w;
    logic [WIDTH-1:0] edge_w;
    logic [WIDTH-1:0] wd_w;
    logic [WIDTH-1:0] rd_w;
    logic             wr_w;
    logic             unused_wd_bits;

    audio_nios_pio_sync #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port_i (in_port),
        .in_sync_o (in_sync_w),
        .edge_o    (edge_w)
    );

    assign wr_w           = avs.chipselect & ~avs.write_n;
    assign wd_w           = avs.writedata[WIDTH-1:0];
    assign unused_wd_bits = ^avs.writedata;

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        if (wr_w) begin
            case (avs.address)
                ADDR_DATA:    out_d  = wd_w;
                ADDR_DIR:     dir_d  = wd_w;
                ADDR_IRQMASK: mask_d = wd_w;
                ADDR_OUTSET:  out_d  = out_q | wd_w;
                ADDR_OUTCLR:  out_d  = out_q & ~wd_w;
                default:      ;
            endcase
        end
        if (!IRQ_EN) begin
            mask_d = '0;
        end
    end

    assign cap_clr_w = (wr_w && avs.address == ADDR_EDGECAP) ? wd_w : '0;

    // Output-direction bits never capture; a fresh edge beats a same-cycle clear.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cap
            assign cap_d[gi] = (cap_q[gi] & ~cap_clr_w[gi]) | (edge_w[gi] & ~dir_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q  <= RESET_VALUE;
            dir_q  <= '0;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    always_comb begin
        rd_w = '0;
        case (avs.address)
            ADDR_DATA:    rd_w = (dir_q & out_q) | (~dir_q & in_sync_w);
            ADDR_DIR:     rd_w = dir_q;
            ADDR_IRQMASK: rd_w = mask_q;
            ADDR_EDGECAP: rd_w = cap_q;
            default:      rd_w = '0;
        endcase
    end

    assign avs.readdata = 32'(rd_w);
    assign out_port     = out_q;
    assign oe           = dir_q;
    assign irq          = IRQ_EN ? |(cap_q & mask_q) : 1'b0;

endmodule
